// File: rtl/multi_pss_search.sv
// multi_pss_search: sign-quantised sliding correlator against run-time loaded references,
// with a peak window, post-detection guard and time-tagged detection reports.
module multi_pss_search #(
    parameter int pDAT_W    = 12,
    parameter int pCORR_L   = 64,
    parameter int pNUM_REF  = 3,
    parameter int pPEAK_WIN = 16,
    parameter int pGUARD    = 256,
    parameter int pTIME_W   = 24,
    localparam int MET_W = $clog2(4*pCORR_L+1),
    localparam int ID_W  = (pNUM_REF > 1) ? $clog2(pNUM_REF) : 1,
    localparam int AW    = $clog2(pCORR_L)
) (
    input  logic                     iclk,
    input  logic                     ireset,
    input  logic                     iena,
    input  logic                     iref_wr,
    input  logic [ID_W-1:0]          iref_sel,
    input  logic [AW-1:0]            iref_addr,
    input  logic [1:0]               iref_data,
    input  logic                     ival,
    input  logic signed [pDAT_W-1:0] idata_I,
    input  logic signed [pDAT_W-1:0] idata_Q,
    input  logic [MET_W-1:0]         ithr,
    output logic                     oval_met,
    output logic [MET_W-1:0]         ometric,
    output logic [ID_W-1:0]          oid_met,
    output logic                     odet,
    output logic [ID_W-1:0]          oid,
    output logic [MET_W-1:0]         opeak,
    output logic [pTIME_W-1:0]       otime,
    output logic                     obusy,
    output logic                     oref_err
);
    localparam int SW = $clog2(2*pCORR_L+1) + 1;
    localparam int FW = $clog2(pCORR_L+1);
    localparam int WW = $clog2(pPEAK_WIN+1);
    localparam int GW = $clog2(pGUARD+1);
    localparam logic signed [SW-1:0] P1 = 1;
    localparam logic signed [SW-1:0] M1 = -1;

    typedef enum logic [1:0] {IDLE, SEARCH, PEAK, GUARD} state_t;

    logic [pCORR_L-1:0] ref_i [pNUM_REF];
    logic [pCORR_L-1:0] ref_q [pNUM_REF];
    logic [pCORR_L-1:0] sh_i, sh_q;
    logic [FW-1:0] fill;
    logic [pTIME_W-1:0] cnt, tag1, tag2, tag3;
    logic v1, v2;
    logic signed [SW-1:0] re [pNUM_REF];
    logic signed [SW-1:0] im [pNUM_REF];
    logic signed [SW-1:0] re_n [pNUM_REF];
    logic signed [SW-1:0] im_n [pNUM_REF];
    logic [MET_W-1:0] best_met;
    logic [ID_W-1:0] best_id;
    state_t state, state_n;
    logic [WW-1:0] win, win_n;
    logic [GW-1:0] g, g_n;
    logic [MET_W-1:0] pk_met, pk_met_n, opeak_n;
    logic [ID_W-1:0] pk_id, pk_id_n, oid_n;
    logic [pTIME_W-1:0] pk_tag, pk_tag_n, otime_n;
    logic odet_n, wr_ok, hit;

    function automatic logic [MET_W-1:0] mag(input logic signed [SW-1:0] a, input logic signed [SW-1:0] b);
        logic [SW-1:0] x, y;
        x = a[SW-1] ? -a : a;
        y = b[SW-1] ? -b : b;
        return MET_W'(x) + MET_W'(y);
    endfunction

    assign wr_ok = iref_wr && state == IDLE && int'(iref_sel) < pNUM_REF;
    assign obusy = state == PEAK || state == GUARD;
    assign hit   = ithr != '0 && ometric >= ithr;

    // Each lag term is a +/-2 unit step, so |Re|+|Im| never exceeds 2L.
    always_comb begin
        for (int k = 0; k < pNUM_REF; k++) begin
            re_n[k] = '0;
            im_n[k] = '0;
            for (int n = 0; n < pCORR_L; n++) begin
                re_n[k] = re_n[k] + (sh_i[n] == ref_i[k][n] ? P1 : M1) + (sh_q[n] == ref_q[k][n] ? P1 : M1);
                im_n[k] = im_n[k] + (sh_q[n] == ref_i[k][n] ? P1 : M1) - (sh_i[n] == ref_q[k][n] ? P1 : M1);
            end
        end
    end

    always_comb begin
        best_met = mag(re[0], im[0]);
        best_id  = '0;
        for (int k = 1; k < pNUM_REF; k++)
            if (mag(re[k], im[k]) > best_met) begin
                best_met = mag(re[k], im[k]);
                best_id  = ID_W'(k);
            end
    end

    always_comb begin
        state_n  = state;
        win_n    = win;
        g_n      = g;
        pk_met_n = pk_met;
        pk_id_n  = pk_id;
        pk_tag_n = pk_tag;
        odet_n   = 1'b0;
        oid_n    = oid;
        opeak_n  = opeak;
        otime_n  = otime;
        if (!iena)
            state_n = IDLE;
        else if (state == IDLE)
            state_n = SEARCH;
        else if (oval_met) begin
            if ((state == SEARCH && hit) || (state == PEAK && ometric > pk_met)) begin
                pk_met_n = ometric;
                pk_id_n  = oid_met;
                pk_tag_n = tag3;
            end
            if (state == SEARCH && hit) begin
                state_n = PEAK;
                win_n   = WW'(1);
            end else if (state == PEAK)
                win_n = win + 1'b1;
            if (state_n == PEAK && win_n == WW'(pPEAK_WIN)) begin
                odet_n  = 1'b1;
                oid_n   = pk_id_n;
                opeak_n = pk_met_n;
                otime_n = pk_tag_n;
                state_n = GUARD;
                g_n     = '0;
            end
            if (state == GUARD) begin
                g_n = g + 1'b1;
                if (g == GW'(pGUARD-1)) state_n = SEARCH;
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            for (int k = 0; k < pNUM_REF; k++) begin
                ref_i[k] <= '0;
                ref_q[k] <= '0;
                re[k]    <= '0;
                im[k]    <= '0;
            end
            {sh_i, sh_q, fill, cnt, tag1, tag2, tag3, v1, v2} <= '0;
            {oval_met, ometric, oid_met, odet, oid, opeak, otime, oref_err} <= '0;
            {win, g, pk_met, pk_id, pk_tag} <= '0;
            state <= IDLE;
        end else begin
            if (wr_ok) begin
                ref_i[iref_sel][iref_addr] <= iref_data[1];
                ref_q[iref_sel][iref_addr] <= iref_data[0];
            end
            oref_err <= iref_wr && !wr_ok;
            if (ival) begin
                sh_i <= {idata_I < 0, sh_i[pCORR_L-1:1]};
                sh_q <= {idata_Q < 0, sh_q[pCORR_L-1:1]};
                tag1 <= cnt;
                cnt  <= cnt + 1'b1;
            end
            fill <= (state == IDLE) ? '0 : (ival && fill != FW'(pCORR_L)) ? fill + 1'b1 : fill;
            v1   <= ival && fill >= FW'(pCORR_L-1);
            v2   <= v1;
            if (v1) begin
                re   <= re_n;
                im   <= im_n;
                tag2 <= tag1;
            end
            oval_met <= v2;
            if (v2) begin
                ometric <= best_met;
                oid_met <= best_id;
                tag3    <= tag2;
            end
            state  <= state_n;
            win    <= win_n;
            g      <= g_n;
            pk_met <= pk_met_n;
            pk_id  <= pk_id_n;
            pk_tag <= pk_tag_n;
            odet   <= odet_n;
            oid    <= oid_n;
            opeak  <= opeak_n;
            otime  <= otime_n;
        end
    end
endmodule

// File: tb/tb_multi_pss_search.sv
// tb_multi_pss_search: directed bench for multi_pss_search; 10-bit time tag so wrap is reachable.
module tb_multi_pss_search;
    logic iclk = 1'b0;
    always #5 iclk = ~iclk;

    logic ireset, iena, iref_wr, ival;
    logic [1:0] iref_sel, iref_data;
    logic [5:0] iref_addr;
    logic signed [11:0] idata_I, idata_Q;
    logic [8:0] ithr;
    logic oval_met, odet, obusy, oref_err;
    logic [8:0] ometric, opeak;
    logic [1:0] oid_met, oid;
    logic [9:0] otime;

    int n_chk, n_fail, nsamp, det_cnt, val_cnt, err_cnt, exp_t, t3, filler;
    logic [8:0] max_met;
    logic [1:0] max_id;
    logic [1:0] rp [3][64];

    multi_pss_search #(.pTIME_W(10)) dut (
        .iclk(iclk), .ireset(ireset), .iena(iena), .iref_wr(iref_wr), .iref_sel(iref_sel),
        .iref_addr(iref_addr), .iref_data(iref_data), .ival(ival), .idata_I(idata_I),
        .idata_Q(idata_Q), .ithr(ithr), .oval_met(oval_met), .ometric(ometric),
        .oid_met(oid_met), .odet(odet), .oid(oid), .opeak(opeak), .otime(otime),
        .obusy(obusy), .oref_err(oref_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Every negedge goes through here, so pulses are never missed.
    task automatic tick;
        @(negedge iclk);
        if (odet === 1'b1) det_cnt++;
        if (oref_err === 1'b1) err_cnt++;
        if (oval_met === 1'b1) begin
            val_cnt++;
            if (ometric > max_met) begin
                max_met = ometric;
                max_id  = oid_met;
            end
        end
    endtask

    task automatic send(input logic [1:0] s);
        tick;
        ival    = 1'b1;
        idata_I = s[1] ? -12'sd300 : 12'sd300;
        idata_Q = s[0] ? -12'sd77 : 12'sd77;
        nsamp++;
    endtask

    task automatic quiet(input int n);
        repeat (n) begin
            tick;
            ival = 1'b0;
        end
    endtask

    task automatic noise(input int n);
        repeat (n) send(2'($urandom_range(0, 3)));
    endtask

    task automatic aligned(input int k);
        for (int j = 0; j < 64; j++) send(rp[k][j]);
        exp_t = (nsamp - 1) % 1024;
    endtask

    task automatic toggle;
        quiet(1);
        iena = 1'b0;
        quiet(1);
        iena = 1'b1;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; nsamp = 0; det_cnt = 0; val_cnt = 0; err_cnt = 0;
        max_met = '0; max_id = 2'd3;
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 64; j++) rp[k][j] = 2'($urandom);
        ireset = 1'b1; iena = 1'b0; ival = 1'b0; idata_I = '0; idata_Q = '0; ithr = '0;
        iref_wr = 1'b1; iref_sel = 2'd0; iref_addr = 6'd5; iref_data = 2'b11;
        repeat (3) tick;
        chk("rst_oval", oval_met, 0);
        chk("rst_metric", ometric, 0);
        chk("rst_det", {odet, oid, opeak}, 0);
        chk("rst_time", otime, 0);
        chk("rst_busy_err", {obusy, oref_err}, 0);
        ireset = 1'b0;
        iref_wr = 1'b0;
        quiet(1);
        iena = 1'b1;
        quiet(1);
        // All-positive window matches every all-zero reference: tie goes to ref 0.
        repeat (64) send(2'b00);
        quiet(1);
        chk("lat_c1", oval_met, 0);
        quiet(1);
        chk("lat_c2", oval_met, 0);
        quiet(1);
        chk("lat_c3", oval_met, 1);
        chk("zero_ref_metric", ometric, 128);
        chk("zero_ref_tie_id", oid_met, 0);
        quiet(1);
        iena = 1'b0;
        quiet(1);
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 64; j++) begin
                tick;
                iref_wr = 1'b1; iref_sel = 2'(k); iref_addr = 6'(j); iref_data = rp[k][j];
            end
        tick;
        iref_wr = 1'b0;
        ithr = 9'd100;
        iena = 1'b1;
        chk("load_no_err", err_cnt, 0);
        quiet(1);
        noise(150); aligned(1); noise(40); quiet(3);
        chk("t2_det_cnt", det_cnt, 1);
        chk("t2_oid", oid, 1);
        chk("t2_peak", opeak, 128);
        chk("t2_time", otime, exp_t);
        chk("t2_guard_busy", obusy, 1);
        toggle;
        noise(70); aligned(2); t3 = exp_t; noise(40); aligned(2); noise(100); quiet(3);
        chk("t3_det_cnt", det_cnt, 2);
        chk("t3_oid", oid, 2);
        chk("t3_peak", opeak, 128);
        chk("t3_time", otime, t3);
        ithr = 9'd0;
        toggle;
        max_met = '0;
        noise(70); aligned(0); noise(20); quiet(3);
        chk("thr0_max", max_met, 128);
        chk("thr0_id", max_id, 0);
        chk("thr0_no_det", det_cnt, 2);
        ithr = 9'd129;
        toggle;
        max_met = '0;
        noise(70); aligned(1); noise(20); quiet(3);
        chk("thr129_max", max_met, 128);
        chk("thr129_id", max_id, 1);
        chk("thr129_no_det", det_cnt, 2);
        ithr = 9'd100;
        toggle;
        noise(70); aligned(0); noise(5); quiet(1);
        chk("t5_peak_busy", obusy, 1);
        iena = 1'b0;
        quiet(2);
        chk("t5_idle", obusy, 0);
        noise(30); quiet(3);
        chk("t5_no_det", det_cnt, 2);
        iena = 1'b1;
        val_cnt = 0;
        noise(63); quiet(3);
        chk("t5_fill63", val_cnt, 0);
        noise(1); quiet(3);
        chk("t5_fill64", val_cnt, 1);
        quiet(1);
        iref_wr = 1'b1; iref_sel = 2'd0; iref_addr = 6'd0; iref_data = ~rp[0][0];
        quiet(1);
        chk("t6_err_search", oref_err, 1);
        iref_wr = 1'b0;
        quiet(1);
        chk("t6_err_pulse", oref_err, 0);
        noise(10); aligned(0); noise(30); quiet(3);
        chk("t6_det_cnt", det_cnt, 3);
        chk("t6_oid", oid, 0);
        chk("t6_ram_kept", opeak, 128);
        chk("t6_time", otime, exp_t);
        quiet(1);
        iena = 1'b0;
        quiet(1);
        iref_wr = 1'b1; iref_sel = 2'd3; iref_addr = 6'd0; iref_data = 2'b11;
        quiet(1);
        chk("t6_err_sel", oref_err, 1);
        iref_wr = 1'b0;
        chk("t6_err_total", err_cnt, 2);
        iena = 1'b1;
        quiet(1);
        filler = (994 - nsamp % 1024 + 1024) % 1024;
        noise(filler); aligned(2); noise(30); quiet(3);
        chk("wrap_det_cnt", det_cnt, 4);
        chk("wrap_oid", oid, 2);
        chk("wrap_time", otime, 33);
        chk("wrap_peak", opeak, 128);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
